// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl sequencer: opcodes, FSM states, operand-select and ALU codes.
// Pure declarations; no logic, no latency.
// No flow control involved.
package cpu_pkg;

  // Opcode values in instr[31:28]; 8..14 are undefined and treated as illegal.
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_ADDI  = 4'd3;
  localparam logic [3:0] OP_SUBI  = 4'd4;
  localparam logic [3:0] OP_AUIPC = 4'd5;
  localparam logic [3:0] OP_JR    = 4'd6;
  localparam logic [3:0] OP_MOV   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // Source for the ALU's first operand (num1).
  localparam logic [1:0] SEL_REG  = 2'd0;
  localparam logic [1:0] SEL_IM   = 2'd1;
  localparam logic [1:0] SEL_PC   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  // ALU operation: subtract computes num1 - num2.
  localparam logic ALU_SUB = 1'b0;
  localparam logic ALU_ADD = 1'b1;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_decoder.sv
// Maps the latched opcode and immediate to ALU controls and writeback/terminate classification.
// Purely combinational, zero cycles.
// No flow control; outputs follow the inputs.
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter int IMM_W = 13
) (
  input  logic [3:0]       op,
  input  logic [IMM_W-1:0] imm,
  output logic             alu_mode,
  output logic [1:0]       num1_cs,
  output logic             wb_reg,
  output logic             wb_pc_alu,
  output logic             is_halt,
  output logic             is_illegal,
  output logic [31:0]      imm_ext
);

  assign imm_ext = {{(32-IMM_W){imm[IMM_W-1]}}, imm};

  // Per-opcode classification; anything not listed falls through to illegal.
  always_comb begin
    alu_mode   = ALU_ADD;
    num1_cs    = SEL_ZERO;
    wb_reg     = 1'b0;
    wb_pc_alu  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_NOP: begin
        alu_mode = ALU_ADD;
        num1_cs  = SEL_ZERO;
      end
      OP_ADD: begin
        alu_mode = ALU_ADD;
        num1_cs  = SEL_REG;
        wb_reg   = 1'b1;
      end
      OP_SUB: begin
        alu_mode = ALU_SUB;
        num1_cs  = SEL_REG;
        wb_reg   = 1'b1;
      end
      OP_ADDI: begin
        alu_mode = ALU_ADD;
        num1_cs  = SEL_IM;
        wb_reg   = 1'b1;
      end
      OP_SUBI: begin
        alu_mode = ALU_SUB;
        num1_cs  = SEL_IM;
        wb_reg   = 1'b1;
      end
      OP_AUIPC: begin
        alu_mode = ALU_ADD;
        num1_cs  = SEL_PC;
        wb_reg   = 1'b1;
      end
      OP_JR: begin
        alu_mode  = ALU_ADD;
        num1_cs   = SEL_PC;
        wb_pc_alu = 1'b1;
      end
      OP_MOV: begin
        alu_mode = ALU_ADD;
        num1_cs  = SEL_ZERO;
        wb_reg   = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/WB loop with terminal HALT, IR and retire counter.
// 4 cycles per instruction when the fetch is acked on its first cycle.
// Fetch stalls in FETCH with im_req held high until im_ack; im_ack elsewhere is ignored.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_STEP = 4,
  parameter int IMM_W   = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  input  logic        im_ack,
  input  logic [31:0] instr,
  output logic [4:0]  reg_raddr0,
  output logic [4:0]  reg_raddr1,
  output logic        ALU_mode,
  output logic [1:0]  num1_CS,
  output logic [31:0] imm_out,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] retired
);

  // The PC adder lives outside this block; the step only has to be sane.
  if (PC_STEP <= 0) begin : g_bad_pc_step
    $error("cpu_ctrl: PC_STEP must be positive");
  end

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic        im_req_q;
  logic        fetch_fire;

  logic        dec_alu_mode;
  logic [1:0]  dec_num1_cs;
  logic        dec_wb_reg;
  logic        dec_wb_pc_alu;
  logic        dec_is_halt;
  logic        dec_is_illegal;
  logic [31:0] dec_imm;

  cpu_decoder #(.IMM_W(IMM_W)) u_decoder (
    .op         (ir_q[31:28]),
    .imm        (ir_q[IMM_W-1:0]),
    .alu_mode   (dec_alu_mode),
    .num1_cs    (dec_num1_cs),
    .wb_reg     (dec_wb_reg),
    .wb_pc_alu  (dec_wb_pc_alu),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal),
    .imm_ext    (dec_imm)
  );

  // im_req is registered so it stays low while in reset and rises on the first edge after release.
  assign im_req     = im_req_q;
  assign fetch_fire = (state_q == FETCH) && im_req_q && im_ack;

  // Register file addresses come straight from IR; they are stable from DECODE onward.
  assign reg_raddr0 = ir_q[22:18];
  assign reg_raddr1 = ir_q[17:13];

  // State, IR, fetch request and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      im_req_q <= 1'b0;
      retired  <= '0;
    end else begin
      state_q  <= state_d;
      im_req_q <= (state_d == FETCH);
      if (fetch_fire) begin
        ir_q <= instr;
      end
      if (state_q == WB) begin
        retired <= retired + 32'd1;
      end
    end
  end

  // Next state and per-state outputs; ALU controls are held from EXEC through WB.
  always_comb begin
    state_d   = state_q;
    ALU_mode  = ALU_SUB;
    num1_CS   = SEL_ZERO;
    imm_out   = '0;
    reg_we    = 1'b0;
    reg_waddr = '0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    halt      = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        if (fetch_fire) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_is_halt || dec_is_illegal) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        ALU_mode = dec_alu_mode;
        num1_CS  = dec_num1_cs;
        imm_out  = dec_imm;
        state_d  = WB;
      end
      WB: begin
        ALU_mode  = dec_alu_mode;
        num1_CS   = dec_num1_cs;
        imm_out   = dec_imm;
        reg_we    = dec_wb_reg;
        reg_waddr = ir_q[27:23];
        pc_we     = 1'b1;
        pc_sel    = dec_wb_pc_alu;
        state_d   = FETCH;
      end
      HALT: begin
        halt    = 1'b1;
        illegal = dec_is_illegal;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule
